// File: rtl/spi_tx_scheduler.sv
// spi_tx_scheduler: round-robin SPI slave transmit frame scheduler.
// Define SPI_TX_CHECKSUM_EN to append an XOR checksum byte per frame.
module spi_tx_scheduler #(
  parameter int NREQ       = 4,
  parameter int DATA_BYTES = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         SCK,
  input  logic                         SS,
  output logic                         MISO,
  input  logic [NREQ-1:0]              req,
  input  logic [NREQ*DATA_BYTES*8-1:0] data,
  output logic [NREQ-1:0]              ack,
  output logic                         busy
);
  localparam int PW = DATA_BYTES * 8;
`ifdef SPI_TX_CHECKSUM_EN
  localparam int FW = PW + 16;
`else
  localparam int FW = PW + 8;
`endif
  localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(FW + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [2:0]      r_sck_s;
  logic [2:0]      r_ss_s;
  logic [FW-1:0]   r_frame;
  logic [CW-1:0]   r_bitcnt;
  logic [GW-1:0]   r_last;
  logic [GW-1:0]   r_grant;
  logic            r_valid;
  logic            r_miso;
  logic            r_busy;
  logic [NREQ-1:0] r_ack;

  logic            w_sck_rise;
  logic            w_sck_fall;
  logic            w_ss_rise;
  logic            w_ss_fall;
  logic            w_last_bit;
  logic            w_hit;
  logic [GW-1:0]   w_gnt;
  logic [GW:0]     w_j;
  logic [7:0]      w_hdr;
  logic [PW-1:0]   w_pl;
  logic [FW-1:0]   w_frame;
`ifdef SPI_TX_CHECKSUM_EN
  logic [7:0]      w_ck;
`endif

  assign w_sck_rise = r_sck_s[1] & ~r_sck_s[2];
  assign w_sck_fall = ~r_sck_s[1] & r_sck_s[2];
  assign w_ss_rise  = r_ss_s[1] & ~r_ss_s[2];
  assign w_ss_fall  = ~r_ss_s[1] & r_ss_s[2];
  assign w_last_bit = (r_bitcnt == CW'(FW - 1));

  assign MISO = r_miso;
  assign busy = r_busy;
  assign ack  = r_ack;

  // Bring the asynchronous SPI pins into the clk domain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sck_s <= '0;
      r_ss_s  <= '0;
    end else begin
      r_sck_s <= {r_sck_s[1:0], SCK};
      r_ss_s  <= {r_ss_s[1:0], SS};
    end
  end

  // Round-robin pick: first pending req after the last granted one.
  always_comb begin
    w_hit = 1'b0;
    w_gnt = '0;
    w_j   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      w_j = {1'b0, r_last} + (GW+1)'(k);
      if (w_j >= (GW+1)'(NREQ))
        w_j = w_j - (GW+1)'(NREQ);
      if (!w_hit && req[w_j[GW-1:0]]) begin
        w_hit = 1'b1;
        w_gnt = w_j[GW-1:0];
      end
    end
  end

  // Assemble the frame for the granted requester (all zero if none).
  always_comb begin
    w_pl = '0;
    for (int i = 0; i < NREQ; i++)
      if (w_hit && GW'(i) == w_gnt)
        w_pl = data[i*PW +: PW];
    w_hdr = w_hit ? {4'hA, 4'(w_gnt)} : 8'h00;
`ifdef SPI_TX_CHECKSUM_EN
    w_ck = w_hdr;
    for (int b = 0; b < DATA_BYTES; b++)
      w_ck = w_ck ^ w_pl[b*8 +: 8];
    w_frame = {w_hdr, w_pl, w_ck};
`else
    w_frame = {w_hdr, w_pl};
`endif
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_state <= S_IDLE;
    else
      r_state <= w_next;
  end

  // Next state; an SS rise returns to IDLE from anywhere.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_ss_fall) w_next = S_LOAD;
      S_LOAD:  w_next = S_SHIFT;
      S_SHIFT: if (w_sck_rise && w_last_bit) w_next = S_DONE;
      S_DONE:  w_next = S_DONE;
      default: w_next = S_IDLE;
    endcase
    if (w_ss_rise)
      w_next = S_IDLE;
  end

  // Frame load, shifting, completion ack and grant history.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_frame  <= '0;
      r_bitcnt <= '0;
      r_last   <= GW'(NREQ - 1);
      r_grant  <= '0;
      r_valid  <= 1'b0;
      r_miso   <= 1'b0;
      r_busy   <= 1'b0;
      r_ack    <= '0;
    end else begin
      r_ack <= '0;
      if (w_ss_rise) begin
        r_busy <= 1'b0;
        r_miso <= 1'b0;
      end else begin
        case (r_state)
          S_LOAD: begin
            r_frame  <= w_frame;
            r_miso   <= w_frame[FW-1];
            r_busy   <= 1'b1;
            r_bitcnt <= '0;
            r_valid  <= w_hit;
            r_grant  <= w_gnt;
          end
          S_SHIFT: begin
            if (w_sck_rise) begin
              r_bitcnt <= r_bitcnt + 1'b1;
              if (w_last_bit) begin
                r_miso <= 1'b0;
                if (r_valid) begin
                  r_ack  <= NREQ'(1) << r_grant;
                  r_last <= r_grant;
                end
              end
            end
            if (w_sck_fall) begin
              r_frame <= {r_frame[FW-2:0], 1'b0};
              r_miso  <= r_frame[FW-2];
            end
          end
          S_DONE:  r_miso <= 1'b0;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_tx_scheduler.sv
// tb_spi_tx_scheduler: SPI master driver plus frame-level reference model.
// Build with SPI_TX_CHECKSUM_EN to exercise the checksum byte.
module tb_spi_tx_scheduler;
  localparam int NREQ = 4;
  localparam int DB   = 2;
`ifdef SPI_TX_CHECKSUM_EN
  localparam int F = 8 * (2 + DB);
`else
  localparam int F = 8 * (1 + DB);
`endif
  localparam int HALF = 8;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   SCK;
  logic                   SS;
  logic                   MISO;
  logic [NREQ-1:0]        req;
  logic [NREQ*DB*8-1:0]   data;
  logic [NREQ-1:0]        ack;
  logic                   busy;

  int checks = 0;
  int errors = 0;
  int lg;
  logic [NREQ-1:0] exp_ack = '0;
  int  ack_total = 0;
  int  ack_bad = 0;
  time ack_t = 0;
  logic [127:0] got;

  always #10 clk = ~clk;

  spi_tx_scheduler #(.NREQ(NREQ), .DATA_BYTES(DB)) dut (
    .clk(clk), .rst(rst), .SCK(SCK), .SS(SS), .MISO(MISO),
    .req(req), .data(data), .ack(ack), .busy(busy)
  );

  // Every cycle: any ack must be exactly the one the model expects.
  always @(negedge clk) begin
    if (!rst && ack !== '0) begin
      ack_total = ack_total + 1;
      ack_t = $time;
      if (ack !== exp_ack) ack_bad = ack_bad + 1;
    end
  end

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: round-robin grant and the bit sequence of the frame.
  task automatic model(output int g, output logic [127:0] f,
                       output bit nul);
    logic [7:0] hdr, ck;
    logic [DB*8-1:0] pl;
    g = -1;
    for (int k = 1; k <= NREQ; k++)
      if (g < 0 && req[(lg + k) % NREQ]) g = (lg + k) % NREQ;
    nul = (g < 0);
    f = '0;
    if (!nul) begin
      hdr = 8'hA0 | 8'(g);
      pl = data[g*DB*8 +: DB*8];
      ck = hdr;
      f = 128'(hdr);
      for (int b = DB - 1; b >= 0; b--) begin
        f = (f << 8) | 128'(pl[b*8 +: 8]);
        ck = ck ^ pl[b*8 +: 8];
      end
`ifdef SPI_TX_CHECKSUM_EN
      f = (f << 8) | 128'(ck);
`endif
    end
  endtask

  task automatic txn(input int nsck, output logic [127:0] bits);
    int g;
    bit nul;
    logic [127:0] f;
    int a0, b0;
    time trise;
    model(g, f, nul);
    exp_ack = (nul || nsck < F) ? '0 : NREQ'(1 << g);
    a0 = ack_total;
    b0 = ack_bad;
    bits = '0;
    trise = 0;
    SS = 1'b0;
    repeat (4) @(negedge clk);
    chk("miso_latency", 128'(MISO), 128'(f[F-1]));
    chk("busy_high", 128'(busy), 128'(1));
    for (int i = 0; i < nsck; i++) begin
      repeat (HALF) @(negedge clk);
      bits = {bits[126:0], MISO};
      chk("miso_bit", 128'(MISO), (i < F) ? 128'(f[F-1-i]) : 128'(0));
      SCK = 1'b1;
      if (i == F - 1) trise = $time;
      repeat (HALF) @(negedge clk);
      SCK = 1'b0;
    end
    repeat (HALF) @(negedge clk);
    SS = 1'b1;
    repeat (6) @(negedge clk);
    chk("busy_low", 128'(busy), 128'(0));
    chk("miso_idle", 128'(MISO), 128'(0));
    chk("ack_pulses", 128'(ack_total - a0),
        128'((exp_ack != '0) ? 1 : 0));
    chk("ack_value", 128'(ack_bad - b0), 128'(0));
    if (exp_ack != '0) begin
      chk("ack_latency_ok", 128'((ack_t - trise) <= 80), 128'(1));
      lg = g;
    end
    exp_ack = '0;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; SS = 1'b1; SCK = 1'b0;
    req = '0; data = '0; lg = NREQ - 1;
    repeat (3) @(negedge clk);
    chk("rst_miso", 128'(MISO), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_ack", 128'(ack), 128'(0));
    rst = 1'b0;
    repeat (4) @(negedge clk);

    req = '0; data = {$urandom, $urandom};
    txn(F, got);
    chk("null_frame", got[F-1:0], '0);

    req = '1;
    for (int t = 0; t < 4; t++) begin
      txn(F, got);
      chk("rr_header", 128'(got[F-1 -: 8]), 128'(8'hA0 + t));
    end

    req = 4'b0001; data[15:0] = 16'hBEEF;
    txn(F, got);
    chk("beef_frame", 128'(got[F-1 -: 24]), 128'(24'hA0BEEF));

    req = 4'b0100; data[47:32] = 16'h5A3C;
    txn(10, got);
    txn(F, got);
    chk("retry_frame", 128'(got[F-1 -: 24]), 128'(24'hA25A3C));

    req = 4'b1011;
    SS = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      repeat (HALF) @(negedge clk); SCK = 1'b1;
      repeat (HALF) @(negedge clk); SCK = 1'b0;
    end
    repeat (HALF) @(negedge clk);
    chk("pre_rst_miso", 128'(MISO), 128'(1));
    rst = 1'b1;
    #1;
    chk("mid_rst_miso", 128'(MISO), 128'(0));
    chk("mid_rst_busy", 128'(busy), 128'(0));
    chk("mid_rst_ack", 128'(ack), 128'(0));
    @(negedge clk);
    rst = 1'b0; SS = 1'b1; lg = NREQ - 1;
    repeat (6) @(negedge clk);
    txn(F, got);
    chk("post_rst_hdr", 128'(got[F-1 -: 8]), 128'(8'hA0));

`ifdef SPI_TX_CHECKSUM_EN
    req = 4'b0010; data[31:16] = 16'h1234;
    txn(F, got);
    chk("cksum_frame", 128'(got[31:0]), 128'(32'hA1123487));
`endif

    for (int t = 0; t < 30; t++) begin
      int r, n;
      req = NREQ'($urandom_range(0, 15));
      data = {$urandom, $urandom};
      r = $urandom_range(0, 3);
      if (r == 0) n = $urandom_range(1, F - 1);
      else if (r == 1) n = F + $urandom_range(1, 3);
      else n = F;
      txn(n, got);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
